// File: rtl/fpu_shift_pkg.sv
// Shared types and helpers for the pipelined alignment shifter.
package fpu_shift_pkg;

    typedef enum logic [1:0] {
        SRL  = 2'b00,
        SRA  = 2'b01,
        SLL  = 2'b10,
        RSVD = 2'b11
    } shift_op_e;

    // Pipeline registers needed for sa_w log levels grouped lps per stage.
    function automatic int num_stages(input int sa_w, input int lps);
        return (sa_w + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/align_shifter_pipe_shift_level.sv
// One combinational log-shifter level (module shift_level).
// Guard/round/sticky tracking is built only when STICKY_EN is defined.
module shift_level #(
    parameter int WIDTH = 24,
    parameter int DIST  = 1
) (
    input  logic             en,
    input  logic             left,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       grs_in,
    output logic [WIDTH-1:0] data_out,
    output logic [2:0]       grs_out
);

    always_comb begin
        data_out = data_in;
        if (en) begin
            data_out = left ? (data_in << DIST) : (data_in >> DIST);
        end
    end

`ifdef STICKY_EN
    localparam int EW = WIDTH + 2;

    logic [EW-1:0] ext;
    logic [EW-1:0] lost_mask;
    logic [1:0]    gr_next;

    // Right shifts always fill with zero here, so G/R/S see only operand bits.
    always_comb begin
        ext       = {data_in, grs_in[2:1]};
        lost_mask = ~({EW{1'b1}} << DIST);
        gr_next   = 2'(ext >> DIST);
        grs_out   = grs_in;
        if (en && !left) begin
            grs_out = {gr_next, grs_in[0] | (|(ext & lost_mask))};
        end
    end
`else
    logic unused_grs;
    assign unused_grs = ^grs_in;
    assign grs_out    = 3'b000;
`endif

endmodule

// File: rtl/align_shifter_pipe.sv
// Pipelined SRL/SRA/SLL alignment shifter with valid/ready flow control.
// Define STICKY_EN to build the guard/round/sticky outputs; otherwise they read 0.
module align_shifter_pipe
    import fpu_shift_pkg::*;
#(
    parameter int WIDTH         = 24,
    parameter int SA_W          = $clog2(WIDTH) + 1,
    parameter int LVL_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SA_W-1:0]  shift_amount,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             guard_out,
    output logic             round_out,
    output logic             sticky_out
);

    localparam int NS = num_stages(SA_W, LVL_PER_STAGE);

    // Per-level chain, indexed by evaluation position (0 = MSB level).
    logic      [SA_W-1:0][WIDTH-1:0] lin_data, lout_data;
    logic      [SA_W-1:0][2:0]       lin_grs, lout_grs;
    logic      [SA_W-1:0][SA_W-1:0]  lin_amt;
    shift_op_e [SA_W-1:0]            lin_op;
    logic      [SA_W-1:0]            lin_sign;

    logic      [NS-1:0][WIDTH-1:0]   st_data;
    logic      [NS-1:0][SA_W-1:0]    st_amt;
    shift_op_e [NS-1:0]              st_op;
    logic      [NS-1:0]              st_sign, st_valid;
`ifdef STICKY_EN
    logic      [NS-1:0][2:0]         st_grs;
`endif
    logic      [NS:0]                rdy;
    logic      [WIDTH-1:0]           fill_vec;

    for (genvar p = 0; p < SA_W; p++) begin : g_lvl
        localparam int LI = SA_W - 1 - p;

        if (p == 0) begin : g_src_in
            assign lin_data[p] = data_in;
            assign lin_grs[p]  = 3'b000;
            assign lin_amt[p]  = shift_amount;
            assign lin_op[p]   = shift_op_e'(op);
            assign lin_sign[p] = data_in[WIDTH-1];
        end else if (p % LVL_PER_STAGE == 0) begin : g_src_reg
            assign lin_data[p] = st_data[p/LVL_PER_STAGE - 1];
`ifdef STICKY_EN
            assign lin_grs[p]  = st_grs[p/LVL_PER_STAGE - 1];
`else
            assign lin_grs[p]  = 3'b000;
`endif
            assign lin_amt[p]  = st_amt[p/LVL_PER_STAGE - 1];
            assign lin_op[p]   = st_op[p/LVL_PER_STAGE - 1];
            assign lin_sign[p] = st_sign[p/LVL_PER_STAGE - 1];
        end else begin : g_src_comb
            assign lin_data[p] = lout_data[p-1];
            assign lin_grs[p]  = lout_grs[p-1];
            assign lin_amt[p]  = lin_amt[p-1];
            assign lin_op[p]   = lin_op[p-1];
            assign lin_sign[p] = lin_sign[p-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << LI)
        ) u_lvl (
            .en       (lin_amt[p][LI]),
            .left     (lin_op[p] == SLL),
            .data_in  (lin_data[p]),
            .grs_in   (lin_grs[p]),
            .data_out (lout_data[p]),
            .grs_out  (lout_grs[p])
        );
    end

    // Sign fill is applied once at the end so the levels stay zero-filling.
    assign fill_vec = (lin_op[SA_W-1] == SRA && lin_sign[SA_W-1])
                      ? ~({WIDTH{1'b1}} >> lin_amt[SA_W-1]) : '0;

    for (genvar k = 0; k < NS; k++) begin : g_stg
        localparam int LP = ((((k + 1) * LVL_PER_STAGE) < SA_W) ?
                             ((k + 1) * LVL_PER_STAGE) : SA_W) - 1;

        logic             up_valid;
        logic [WIDTH-1:0] nxt_data;
        logic             valid_q;
        logic             sign_q;
        logic [WIDTH-1:0] data_q;
        logic [SA_W-1:0]  amt_q;
        shift_op_e        op_q;

        if (k == 0) begin : g_up_in
            assign up_valid = in_valid;
        end else begin : g_up_stg
            assign up_valid = st_valid[k-1];
        end

        if (k == NS - 1) begin : g_fill
            assign nxt_data = lout_data[LP] | fill_vec;
        end else begin : g_pass
            assign nxt_data = lout_data[LP];
        end

        assign rdy[k] = !valid_q || rdy[k+1];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                amt_q   <= '0;
                op_q    <= SRL;
                sign_q  <= 1'b0;
            end else if (rdy[k]) begin
                valid_q <= up_valid;
                if (up_valid) begin
                    data_q <= nxt_data;
                    amt_q  <= lin_amt[LP];
                    op_q   <= lin_op[LP];
                    sign_q <= lin_sign[LP];
                end
            end
        end

`ifdef STICKY_EN
        logic [2:0] grs_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                grs_q <= 3'b000;
            end else if (rdy[k] && up_valid) begin
                grs_q <= lout_grs[LP];
            end
        end

        assign st_grs[k] = grs_q;
`endif

        assign st_valid[k] = valid_q;
        assign st_data[k]  = data_q;
        assign st_amt[k]   = amt_q;
        assign st_op[k]    = op_q;
        assign st_sign[k]  = sign_q;
    end

    assign rdy[NS]   = out_ready;
    assign in_ready  = rdy[0];
    assign out_valid = st_valid[NS-1];
    assign data_out  = st_data[NS-1];

    logic unused_tail;
    assign unused_tail = ^{st_amt[NS-1], st_op[NS-1], st_sign[NS-1]};

`ifdef STICKY_EN
    assign guard_out  = st_grs[NS-1][2];
    assign round_out  = st_grs[NS-1][1];
    assign sticky_out = st_grs[NS-1][0];
`else
    logic unused_grs;
    assign unused_grs = ^lout_grs;
    assign guard_out  = 1'b0;
    assign round_out  = 1'b0;
    assign sticky_out = 1'b0;
`endif

endmodule

// File: tb/tb_align_shifter_pipe.sv
// Self-checking bench for align_shifter_pipe: vector table, streaming, stall and reset.
module tb_align_shifter_pipe;

    localparam int W   = 24;
    localparam int SAW = 6;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   data_in = '0;
    logic [SAW-1:0] shift_amount = '0;
    logic [1:0]     op = 2'b00;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   data_out;
    logic           guard_out, round_out, sticky_out;

    always #5 clk = ~clk;

    align_shifter_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .shift_amount (shift_amount),
        .op           (op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .guard_out    (guard_out),
        .round_out    (round_out),
        .sticky_out   (sticky_out)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         g;
        logic         r;
        logic         s;
    } res_t;

    typedef struct {
        logic [W-1:0] d;
        int           amt;
        logic [1:0]   op;
        res_t         exp;
    } vec_t;

    res_t  q[$];
    int    out_cyc_q[$];
    vec_t  tbl[15];
    int    errors = 0, checks = 0, cyc = 0;
    int    out_beats = 0, acc_beats = 0, last_out_cyc = 0, last_acc_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic res_t strip_grs(input res_t x);
        res_t y = x;
`ifndef STICKY_EN
        y.g = 1'b0;
        y.r = 1'b0;
        y.s = 1'b0;
`endif
        return y;
    endfunction

    // Infinite-precision reference: 64 fraction bits hold everything shifted out.
    function automatic res_t model(input logic [W-1:0] d, input int amt, input logic [1:0] o);
        res_t                m;
        logic [W+63:0]        ext;
        logic signed [W+63:0] sx;
        ext = {d, 64'b0} >> amt;
        sx  = {d, 64'b0};
        sx  = sx >>> amt;
        if (o == 2'b10) begin
            m.data = (amt >= W) ? '0 : (d << amt);
            m.g = 1'b0; m.r = 1'b0; m.s = 1'b0;
        end else begin
            m.data = (o == 2'b01) ? sx[W+63:64] : ext[W+63:64];
            m.g = ext[63];
            m.r = ext[62];
            m.s = |ext[61:0];
        end
        return strip_grs(m);
    endfunction

    function automatic vec_t mk(input logic [W-1:0] d, input int a, input logic [1:0] o,
                                input logic [W-1:0] ed, input logic g, input logic r, input logic s);
        vec_t v;
        v.d = d; v.amt = a; v.op = o;
        v.exp.data = ed; v.exp.g = g; v.exp.r = r; v.exp.s = s;
        v.exp = strip_grs(v.exp);
        return v;
    endfunction

    task automatic step(input logic rst, input logic v, input logic [W-1:0] d, input int a,
                        input logic [1:0] o, input logic ordy, input res_t e);
        res_t got, want;
        @(negedge clk);
        rst_n = rst; in_valid = v; data_in = d; shift_amount = a[SAW-1:0];
        op = o; out_ready = ordy;
        #1;
        cyc++;
        if (rst) begin
            got = {data_out, guard_out, round_out, sticky_out};
            if (out_valid) begin
                check("output_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    if (out_ready) begin
                        want = q.pop_front();
                        check("result", got, want);
                        out_beats++;
                        last_out_cyc = cyc;
                        out_cyc_q.push_back(cyc);
                    end else begin
                        check("stall_hold", got, q[0]);
                    end
                end
            end
            if (v && in_ready) begin
                q.push_back(e);
                acc_beats++;
                last_acc_cyc = cyc;
            end
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b1, 1'b0, '0, 0, 2'b00, ordy, '0);
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 20 && q.size() != 0; n++) idle(1'b1);
        check(name, q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] bd[5];
        int           ba[5];
        logic [1:0]   bo[5];
        int           ob0, ab0, idx, acc_cyc, a;
        logic [W-1:0] d;
        logic [1:0]   o;

        tbl[0]  = mk(24'hC00001,  1, 2'b00, 24'h600000, 1, 0, 0);
        tbl[1]  = mk(24'h00000F,  3, 2'b00, 24'h000001, 1, 1, 1);
        tbl[2]  = mk(24'h800000, 24, 2'b00, 24'h000000, 1, 0, 0);
        tbl[3]  = mk(24'h000005, 31, 2'b00, 24'h000000, 0, 0, 1);
        tbl[4]  = mk(24'h800000,  4, 2'b01, 24'hF80000, 0, 0, 0);
        tbl[5]  = mk(24'h800000, 30, 2'b01, 24'hFFFFFF, 0, 0, 1);
        tbl[6]  = mk(24'h000001, 23, 2'b10, 24'h800000, 0, 0, 0);
        tbl[7]  = mk(24'h000001, 24, 2'b10, 24'h000000, 0, 0, 0);
        tbl[8]  = mk(24'hABCDEF,  0, 2'b00, 24'hABCDEF, 0, 0, 0);
        tbl[9]  = mk(24'hF00000,  4, 2'b11, 24'h0F0000, 0, 0, 0);
        tbl[10] = mk(24'h7FFFFF,  8, 2'b01, 24'h007FFF, 1, 1, 1);
        tbl[11] = mk(24'h800000, 25, 2'b00, 24'h000000, 0, 1, 0);
        tbl[12] = mk(24'h900000, 25, 2'b01, 24'hFFFFFF, 0, 1, 1);
        tbl[13] = mk(24'hFFFFFF, 63, 2'b10, 24'h000000, 0, 0, 0);
        tbl[14] = mk(24'hABCDEF,  0, 2'b01, 24'hABCDEF, 0, 0, 0);

        // Reset with in_valid high: beats offered during reset must be ignored.
        step(1'b0, 1'b1, 24'h123456, 5, 2'b00, 1'b1, '0);
        step(1'b0, 1'b1, 24'h123456, 5, 2'b00, 1'b1, '0);
        idle(1'b1);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_grs", {guard_out, round_out, sticky_out}, 0);
        check("rst_in_ready", in_ready, 1);

        // Single beat latency.
        ab0 = acc_beats;
        step(1'b1, 1'b1, tbl[0].d, tbl[0].amt, tbl[0].op, 1'b1, tbl[0].exp);
        check("lat_accept", acc_beats - ab0, 1);
        acc_cyc = last_acc_cyc;
        ob0 = out_beats;
        for (int n = 0; n < 20 && out_beats == ob0; n++) idle(1'b1);
        check("latency", last_out_cyc - acc_cyc, LAT);

        // Vector table, streamed back to back.
        for (int i = 0; i < 15; i++)
            step(1'b1, 1'b1, tbl[i].d, tbl[i].amt, tbl[i].op, 1'b1, tbl[i].exp);
        drain("table_drain");

        // Back-to-back random stream.
        ob0 = out_beats;
        for (int i = 0; i < 8; i++) begin
            d = W'($urandom);
            a = int'($urandom_range(0, 63));
            o = 2'($urandom_range(0, 3));
            step(1'b1, 1'b1, d, a, o, 1'b1, model(d, a, o));
            check("stream_in_ready", in_ready, 1);
        end
        drain("stream_drain");
        check("stream_count", out_beats - ob0, 8);
        if (out_beats - ob0 == 8)
            check("stream_consecutive", out_cyc_q[ob0 + 7] - out_cyc_q[ob0], 7);

        // Stall: five beats offered with out_ready low.
        for (int i = 0; i < 5; i++) begin
            bd[i] = W'($urandom);
            ba[i] = int'($urandom_range(0, 40));
            bo[i] = 2'($urandom_range(0, 2));
        end
        ob0 = out_beats; ab0 = acc_beats; idx = 0;
        for (int n = 0; n < 8; n++) begin
            a = acc_beats;
            step(1'b1, 1'b1, bd[idx], ba[idx], bo[idx], 1'b0, model(bd[idx], ba[idx], bo[idx]));
            if (acc_beats != a) idx++;
        end
        check("stall_accepted", acc_beats - ab0, 3);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        for (int n = 0; n < 20 && idx < 5; n++) begin
            a = acc_beats;
            step(1'b1, 1'b1, bd[idx], ba[idx], bo[idx], 1'b1, model(bd[idx], ba[idx], bo[idx]));
            if (acc_beats != a) idx++;
        end
        drain("stall_drain");
        check("stall_count", out_beats - ob0, 5);

        // Reset with two beats in flight.
        step(1'b1, 1'b1, tbl[1].d, tbl[1].amt, tbl[1].op, 1'b1, tbl[1].exp);
        step(1'b1, 1'b1, tbl[4].d, tbl[4].amt, tbl[4].op, 1'b1, tbl[4].exp);
        step(1'b0, 1'b1, tbl[5].d, tbl[5].amt, tbl[5].op, 1'b1, '0);
        q.delete();
        idle(1'b1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_grs", {guard_out, round_out, sticky_out}, 0);
        check("midrst_in_ready", in_ready, 1);
        for (int n = 0; n < 6; n++) begin
            idle(1'b1);
            check("no_stale", out_valid, 0);
        end
        ob0 = out_beats;
        step(1'b1, 1'b1, tbl[10].d, tbl[10].amt, tbl[10].op, 1'b1, tbl[10].exp);
        drain("post_rst_drain");
        check("post_rst_count", out_beats - ob0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
